// File: rtl/cmult_pkg.sv
// Shared constants and types for the shared complex-multiplier arbiter.
package cmult_pkg;

    localparam int N   = 8;
    localparam int LAT = 3;

    // Requester id travelling alongside each product, plus its valid bit.
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // Bits needed to count from 0 up to max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // The in-flight count never exceeds LAT+1.
    localparam int IFW = cnt_w(LAT + 1);

endpackage

// File: rtl/cmult_pipe.sv
// Signed complex multiplier, four real multipliers, LAT register stages from
// inputs to c_r/c_i. Products are summed in 2N bits and wrap modulo 2^(2N).
module cmult_pipe
    import cmult_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [N-1:0]   a_r,
    input  logic signed [N-1:0]   a_i,
    input  logic signed [N-1:0]   b_r,
    input  logic signed [N-1:0]   b_i,
    output logic signed [2*N-1:0] c_r,
    output logic signed [2*N-1:0] c_i
);

    localparam int W2 = 2 * N;

    logic signed [W2-1:0] rr_p0, ii_p0, ri_p0, ir_p0;
    logic signed [W2-1:0] sr_p0, si_p0;

    // Stage 0: the four partial products, full width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_p0 <= '0;
            ii_p0 <= '0;
            ri_p0 <= '0;
            ir_p0 <= '0;
        end else begin
            rr_p0 <= W2'(a_r) * W2'(b_r);
            ii_p0 <= W2'(a_i) * W2'(b_i);
            ri_p0 <= W2'(a_r) * W2'(b_i);
            ir_p0 <= W2'(a_i) * W2'(b_r);
        end
    end

    assign sr_p0 = rr_p0 - ii_p0;
    assign si_p0 = ri_p0 + ir_p0;

    generate
        if (LAT == 1) begin : g_nodly
            assign c_r = sr_p0;
            assign c_i = si_p0;
        end else begin : g_dly
            logic signed [W2-1:0] dr [LAT-1];
            logic signed [W2-1:0] di [LAT-1];

            // Stages 1..LAT-1: delay line that pads the sums out to LAT clocks.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < LAT-1; i++) begin
                        dr[i] <= '0;
                        di[i] <= '0;
                    end
                end else begin
                    dr[0] <= sr_p0;
                    di[0] <= si_p0;
                    for (int i = 1; i < LAT-1; i++) begin
                        dr[i] <= dr[i-1];
                        di[i] <= di[i-1];
                    end
                end
            end

            assign c_r = dr[LAT-2];
            assign c_i = di[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/cmult_arbiter.sv
// Round-robin sharing of one pipelined complex multiplier between two
// requesters. A tag pipeline matched to the multiplier latency steers each
// product back to the requester that issued it.
module cmult_arbiter
    import cmult_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [N-1:0]   a_r0,
    input  logic [N-1:0]   a_i0,
    input  logic [N-1:0]   b_r0,
    input  logic [N-1:0]   b_i0,
    input  logic [N-1:0]   a_r1,
    input  logic [N-1:0]   a_i1,
    input  logic [N-1:0]   b_r1,
    input  logic [N-1:0]   b_i1,
    output logic [1:0]     res_valid,
    output logic [2*N-1:0] res_r,
    output logic [2*N-1:0] res_i,
    output logic [IFW-1:0] inflight
);

    logic                   last_grant;
    logic                   accept;
    logic                   acc_id;
    logic                   ret;
    logic signed [N-1:0]    ar_mx, ai_mx, br_mx, bi_mx;
    logic signed [N-1:0]    ar_p0, ai_p0, br_p0, bi_p0;
    tag_t                   tag_p0;
    tag_t                   tag_sh [LAT];
    logic signed [2*N-1:0]  cr, ci;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        req_ready = 2'b00;
        if (reset) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign accept = |(req_valid & req_ready);
    assign acc_id = req_ready[1];
    assign ret    = tag_sh[LAT-1].vld;

    // Operand mux steered by the grant.
    always_comb begin
        ar_mx = a_r0;
        ai_mx = a_i0;
        br_mx = b_r0;
        bi_mx = b_i0;
        if (acc_id) begin
            ar_mx = a_r1;
            ai_mx = a_i1;
            br_mx = b_r1;
            bi_mx = b_i1;
        end
    end

    // Remember the last winner; requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= acc_id;
    end

    // Input register: operands load only on accept so idle X never enters.
    always_ff @(posedge clk) begin
        if (accept) begin
            ar_p0 <= ar_mx;
            ai_p0 <= ai_mx;
            br_p0 <= br_mx;
            bi_p0 <= bi_mx;
        end
    end

    // Tag register alongside the input register, then LAT-deep tag shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_p0 <= '0;
            for (int i = 0; i < LAT; i++)
                tag_sh[i] <= '0;
        end else begin
            tag_p0.vld <= accept;
            tag_p0.id  <= acc_id;
            tag_sh[0]  <= tag_p0;
            for (int i = 1; i < LAT; i++)
                tag_sh[i] <= tag_sh[i-1];
        end
    end

    cmult_pipe u_pipe (
        .clk   (clk),
        .reset (reset),
        .a_r   (ar_p0),
        .a_i   (ai_p0),
        .b_r   (br_p0),
        .b_i   (bi_p0),
        .c_r   (cr),
        .c_i   (ci)
    );

    // Result register: one-cycle valid pulse to the tagged requester; data holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid <= 2'b00;
            res_r     <= '0;
            res_i     <= '0;
        end else begin
            res_valid <= ret ? (tag_sh[LAT-1].id ? 2'b10 : 2'b01) : 2'b00;
            if (ret) begin
                res_r <= cr;
                res_i <= ci;
            end
        end
    end

    // Outstanding-request counter: +1 per accept, -1 per returned result.
    always_ff @(posedge clk) begin
        if (!reset)
            inflight <= '0;
        else
            inflight <= inflight + IFW'(accept) - IFW'(ret);
    end

endmodule

// File: tb/tb_cmult_arbiter.sv
// Directed bench for cmult_arbiter with hand-computed expected values.
module tb_cmult_arbiter;
    import cmult_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [N-1:0]   a_r0, a_i0, b_r0, b_i0;
    logic [N-1:0]   a_r1, a_i1, b_r1, b_i1;
    logic [1:0]     res_valid;
    logic [2*N-1:0] res_r, res_i;
    logic [IFW-1:0] inflight;

    int nvec = 0;
    int nerr = 0;

    cmult_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a_r0      (a_r0),
        .a_i0      (a_i0),
        .b_r0      (b_r0),
        .b_i0      (b_i0),
        .a_r1      (a_r1),
        .a_i1      (a_i1),
        .b_r1      (b_r1),
        .b_i1      (b_i1),
        .res_valid (res_valid),
        .res_r     (res_r),
        .res_i     (res_i),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int ar, input int ai, input int br, input int bi);
        a_r0 = N'(ar); a_i0 = N'(ai); b_r0 = N'(br); b_i0 = N'(bi);
    endtask

    task automatic set1(input int ar, input int ai, input int br, input int bi);
        a_r1 = N'(ar); a_i1 = N'(ai); b_r1 = N'(br); b_i1 = N'(bi);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 2'b11;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);

        // 1: reset held two clocks with both requesters asking
        #1;
        chk("rst_ready_comb", 16'(req_ready), 16'h0);
        step();
        chk("rst_ready", 16'(req_ready), 16'h0);
        chk("rst_valid", 16'(res_valid), 16'h0);
        chk("rst_inflight", 16'(inflight), 16'h0);
        step();
        chk("rst_ready2", 16'(req_ready), 16'h0);
        chk("rst_res_r", res_r, 16'h0);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 16'(req_ready), 16'h1);
        req_valid = 2'b00;
        #1;
        chk("idle_ready", 16'(req_ready), 16'h0);

        // 2: single request (1+2i)(3+4i) = -5+10i
        step();
        req_valid = 2'b01;
        set0(1, 2, 3, 4);
        #1;
        chk("single_ready", 16'(req_ready), 16'h1);
        step();
        req_valid = 2'b00;
        set0(0, 0, 0, 0);
        chk("single_inflight", 16'(inflight), 16'h1);
        for (int i = 0; i < LAT; i++) begin
            step();
            chk("single_early", 16'(res_valid), 16'h0);
        end
        step();
        chk("single_valid", 16'(res_valid), 16'h1);
        chk("single_r", res_r, -16'sd5);
        chk("single_i", res_i, 16'd10);
        chk("single_inflight0", 16'(inflight), 16'h0);
        step();
        chk("single_pulse", 16'(res_valid), 16'h0);
        chk("single_hold_r", res_r, -16'sd5);

        // 4: wrap corner on requester 1, a=b=-128-128i -> 0 - 32768i
        req_valid = 2'b10;
        set1(-128, -128, -128, -128);
        #1;
        chk("wrap_ready", 16'(req_ready), 16'h2);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < LAT; i++) step();
        step();
        chk("wrap_valid", 16'(res_valid), 16'h2);
        chk("wrap_r", res_r, 16'h0000);
        chk("wrap_i", res_i, 16'h8000);

        // 3: contention, both held valid four cycles
        req_valid = 2'b11;
        set0(2, 3, 4, 5);
        set1(3, 4, 5, 6);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_grant", 16'(req_ready), (i % 2 == 0) ? 16'h1 : 16'h2);
            step();
        end
        req_valid = 2'b00;
        chk("cont_peak", 16'(inflight), 16'(LAT + 1));
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) begin
                chk("cont_v0", 16'(res_valid), 16'h1);
                chk("cont_r0", res_r, -16'sd7);
                chk("cont_i0", res_i, 16'd22);
            end else begin
                chk("cont_v1", 16'(res_valid), 16'h2);
                chk("cont_r1", res_r, -16'sd9);
                chk("cont_i1", res_i, 16'd38);
            end
            chk("cont_drain", 16'(inflight), 16'(3 - i));
        end
        step();
        chk("cont_done", 16'(res_valid), 16'h0);

        // 6: idle fairness, req1 alone then both valid -> req0, then req1
        set0(1, 2, 3, 4);
        set1(0, 1, 0, 1);
        req_valid = 2'b10;
        #1;
        chk("fair_solo", 16'(req_ready), 16'h2);
        step();
        req_valid = 2'b11;
        #1;
        chk("fair_first", 16'(req_ready), 16'h1);
        step();
        #1;
        chk("fair_second", 16'(req_ready), 16'h2);
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("fair_v_a", 16'(res_valid), 16'h2);
        chk("fair_r_a", res_r, -16'sd1);
        chk("fair_i_a", res_i, 16'd0);
        step();
        chk("fair_v_b", 16'(res_valid), 16'h1);
        chk("fair_r_b", res_r, -16'sd5);
        step();
        chk("fair_v_c", 16'(res_valid), 16'h2);
        step();

        // 5: reset mid-flight discards three accepted requests
        req_valid = 2'b01;
        set0(5, 5, 5, 5);
        for (int i = 0; i < 3; i++) step();
        chk("mid_inflight", 16'(inflight), 16'h3);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_ready", 16'(req_ready), 16'h0);
        step();
        chk("mid_rst_inflight", 16'(inflight), 16'h0);
        reset = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            chk("mid_no_result", 16'(res_valid), 16'h0);
        end
        req_valid = 2'b11;
        #1;
        chk("mid_tie_ready", 16'(req_ready), 16'h1);
        req_valid = 2'b01;
        set0(2, 0, 3, 0);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < LAT; i++) step();
        step();
        chk("fresh_valid", 16'(res_valid), 16'h1);
        chk("fresh_r", res_r, 16'd6);
        chk("fresh_i", res_i, 16'd0);
        chk("fresh_inflight", 16'(inflight), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
